thread_state_mem: RTL and testbench

//  Per-thread state store: the write/hold end of the thread-state interface whose read side is the
//  CPU thread scheduler. Keeps one THREAD_STATE code per thread, accepts updates from the CPU
//  (execution) side and the I/O (load/unload) side, and serves lookahead reads to the scheduler.

---
 rtl/thread_state_mem_pkg.sv | 33 +++
 rtl/thread_state_mem_if.sv | 31 +++
 rtl/thread_state_mem_scan.sv | 22 ++
 rtl/thread_state_mem.sv | 132 +++++++++++++
 tb/tb_thread_state_mem.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/thread_state_mem_pkg.sv
// Shared thread-state encoding and transition legality for the thread-state store and scheduler.
package thread_state_mem_pkg;

    localparam int THREAD_STATE_MSB = 1;

    typedef logic [THREAD_STATE_MSB:0] thread_state_t;

    localparam thread_state_t TS_NONE   = 2'd0;
    localparam thread_state_t TS_WR_RDY = 2'd1;
    localparam thread_state_t TS_BUSY   = 2'd2;
    localparam thread_state_t TS_RD_RDY = 2'd3;

    // One write port's registered strobe and requested state; the thread index travels beside it.
    typedef struct packed {
        logic          en;
        thread_state_t st;
    } wr_req_t;

    function automatic int thread_num_msb(input int n_threads);
        return (n_threads > 2) ? $clog2(n_threads) - 1 : 0;
    endfunction

    function automatic logic cpu_legal(input thread_state_t cur, input thread_state_t nxt);
        return ((cur == TS_WR_RDY) && (nxt == TS_BUSY)) ||
               ((cur == TS_BUSY) && ((nxt == TS_WR_RDY) || (nxt == TS_RD_RDY)));
    endfunction

    function automatic logic io_legal(input thread_state_t cur, input thread_state_t nxt);
        return ((cur == TS_NONE) && (nxt == TS_WR_RDY)) ||
               ((cur == TS_RD_RDY) && (nxt == TS_NONE));
    endfunction

endpackage

// File: rtl/thread_state_mem_if.sv
// Bundle between the thread-state store (slave) and its scheduler / CPU / I/O clients (master).
interface thread_state_mem_if #(
    parameter int N_THREADS_MSB = 0
);
    import thread_state_mem_pkg::*;

    // Write strobes are fire-and-forget: a write is taken on every CLK edge where *_wr_en is high.
    // There is no ready/back-pressure; the store accepts one write per port per cycle, always.
    logic [N_THREADS_MSB:0]    ts_rd_num;
    logic [THREAD_STATE_MSB:0] ts_rd;
    logic                      ts_wr_en;
    logic [N_THREADS_MSB:0]    ts_wr_num;
    logic [THREAD_STATE_MSB:0] ts_wr;
    logic                      io_wr_en;
    logic [N_THREADS_MSB:0]    io_wr_num;
    logic [THREAD_STATE_MSB:0] io_wr;
    logic                      rd_rdy_any;
    logic [N_THREADS_MSB:0]    rd_rdy_num;
    logic                      err;

    modport master (
        output ts_rd_num, ts_wr_en, ts_wr_num, ts_wr, io_wr_en, io_wr_num, io_wr,
        input  ts_rd, rd_rdy_any, rd_rdy_num, err
    );

    modport slave (
        input  ts_rd_num, ts_wr_en, ts_wr_num, ts_wr, io_wr_en, io_wr_num, io_wr,
        output ts_rd, rd_rdy_any, rd_rdy_num, err
    );

endinterface

// File: rtl/thread_state_mem_scan.sv
// Lowest-index priority encoder over the per-thread RD_RDY bits; purely combinational.
module thread_state_mem_scan #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] rdy,
    output logic         any,
    output logic [W-1:0] num
);

    // Walking downwards lets the lowest set bit win the last assignment.
    always_comb begin
        any = |rdy;
        num = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                num = W'(i);
            end
        end
    end

endmodule

// File: rtl/thread_state_mem.sv
// Per-thread state store: two write ports through a 2-stage legality-checked pipeline,
// a registered lookahead read for the scheduler and a registered RD_RDY scan for the unloader.
module thread_state_mem
    import thread_state_mem_pkg::*;
#(
    parameter int N_CORES       = -1,
    parameter int N_THREADS     = 2 * N_CORES,
    parameter int N_THREADS_MSB = thread_num_msb(N_THREADS)
) (
    input logic               CLK,
    input logic               RESET_N,
    thread_state_mem_if.slave bus
);

    localparam int N_ENT = (N_THREADS < 1) ? 1 : N_THREADS;
    localparam int NUM_W = N_THREADS_MSB + 1;

    typedef logic [N_THREADS_MSB:0] num_t;

    wr_req_t       s1_ts;
    wr_req_t       s1_io;
    num_t          s1_ts_num;
    num_t          s1_io_num;

    thread_state_t st_q [N_ENT];
    thread_state_t st_d [N_ENT];
    logic [N_ENT-1:0] rdy_vec;

    thread_state_t ts_cur;
    thread_state_t io_cur;
    thread_state_t rd_cur;
    logic          ts_hit;
    logic          io_hit;
    logic          ts_ok;
    logic          io_ok;
    logic          collide;
    logic          err_set;

    logic          scan_any;
    num_t          scan_num;

    thread_state_t ts_rd_q;
    logic          rd_rdy_any_q;
    num_t          rd_rdy_num_q;
    logic          err_q;

    // Index decode by comparison so an out-of-range thread number simply finds no entry.
    always_comb begin
        ts_cur = TS_NONE;
        io_cur = TS_NONE;
        rd_cur = TS_NONE;
        ts_hit = 1'b0;
        io_hit = 1'b0;
        for (int i = 0; i < N_ENT; i++) begin
            if (s1_ts_num == num_t'(i)) begin
                ts_cur = st_q[i];
                ts_hit = 1'b1;
            end
            if (s1_io_num == num_t'(i)) begin
                io_cur = st_q[i];
                io_hit = 1'b1;
            end
            if (bus.ts_rd_num == num_t'(i)) begin
                rd_cur = st_q[i];
            end
        end
    end

    // The CPU side wins a same-thread collision; the I/O write is dropped and flagged.
    always_comb begin
        collide = s1_ts.en && s1_io.en && (s1_ts_num == s1_io_num);
        ts_ok   = s1_ts.en && ts_hit && cpu_legal(ts_cur, s1_ts.st);
        io_ok   = s1_io.en && !collide && io_hit && io_legal(io_cur, s1_io.st);
        err_set = (s1_ts.en && !ts_ok) || (s1_io.en && !io_ok);
    end

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            st_d[i]    = st_q[i];
            rdy_vec[i] = (st_q[i] == TS_RD_RDY);
            if (ts_ok && (s1_ts_num == num_t'(i))) begin
                st_d[i] = s1_ts.st;
            end else if (io_ok && (s1_io_num == num_t'(i))) begin
                st_d[i] = s1_io.st;
            end
        end
    end

    thread_state_mem_scan #(
        .N (N_ENT),
        .W (NUM_W)
    ) u_scan (
        .rdy (rdy_vec),
        .any (scan_any),
        .num (scan_num)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            s1_ts        <= '0;
            s1_io        <= '0;
            s1_ts_num    <= '0;
            s1_io_num    <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                st_q[i] <= TS_NONE;
            end
            ts_rd_q      <= TS_NONE;
            rd_rdy_any_q <= 1'b0;
            rd_rdy_num_q <= '0;
            err_q        <= 1'b0;
        end else begin
            s1_ts        <= '{en: bus.ts_wr_en, st: bus.ts_wr};
            s1_io        <= '{en: bus.io_wr_en, st: bus.io_wr};
            s1_ts_num    <= bus.ts_wr_num;
            s1_io_num    <= bus.io_wr_num;
            st_q         <= st_d;
            // No bypass: the scheduler's hold-off assumes the array value, not the pending write.
            ts_rd_q      <= rd_cur;
            rd_rdy_any_q <= scan_any;
            rd_rdy_num_q <= scan_num;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ts_rd      = ts_rd_q;
    assign bus.rd_rdy_any = rd_rdy_any_q;
    assign bus.rd_rdy_num = rd_rdy_num_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_thread_state_mem.sv
// Directed bench for thread_state_mem with 3 cores (6 threads, so indices 6 and 7 are out of range).
module tb_thread_state_mem;
    import thread_state_mem_pkg::*;

    localparam int N_CORES   = 3;
    localparam int N_THREADS = 6;
    localparam int MSB       = 2;

    typedef logic [MSB:0] num_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    thread_state_mem_if #(.N_THREADS_MSB(MSB)) bus ();

    thread_state_mem #(.N_CORES(N_CORES)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input int num, input thread_state_t st);
        bus.ts_wr_en  = 1'b1;
        bus.ts_wr_num = num_t'(num);
        bus.ts_wr     = st;
        step();
        bus.ts_wr_en  = 1'b0;
    endtask

    task automatic io_wr(input int num, input thread_state_t st);
        bus.io_wr_en  = 1'b1;
        bus.io_wr_num = num_t'(num);
        bus.io_wr     = st;
        step();
        bus.io_wr_en  = 1'b0;
    endtask

    task automatic both_wr(input int tn, input thread_state_t ts, input int in, input thread_state_t is);
        bus.ts_wr_en  = 1'b1;
        bus.ts_wr_num = num_t'(tn);
        bus.ts_wr     = ts;
        bus.io_wr_en  = 1'b1;
        bus.io_wr_num = num_t'(in);
        bus.io_wr     = is;
        step();
        bus.ts_wr_en  = 1'b0;
        bus.io_wr_en  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int num, input thread_state_t exp);
        bus.ts_rd_num = num_t'(num);
        step();
        chk(tag, 32'(bus.ts_rd), 32'(exp));
    endtask

    // Scoreboard: reads every thread in order against the expected queue filled by the caller
    task automatic sweep(input string tag);
        for (int i = 0; i < N_THREADS; i++) begin
            bus.ts_rd_num = num_t'(i);
            step();
            chk($sformatf("%s_t%0d", tag, i), 32'(bus.ts_rd), exp_q.pop_front());
        end
    endtask

    task automatic push_all(input thread_state_t st);
        for (int i = 0; i < N_THREADS; i++) exp_q.push_back(32'(st));
    endtask

    initial begin
        bus.ts_rd_num = '0;
        bus.ts_wr_en  = 1'b0;
        bus.ts_wr_num = '0;
        bus.ts_wr     = TS_NONE;
        bus.io_wr_en  = 1'b0;
        bus.io_wr_num = '0;
        bus.io_wr     = TS_NONE;

        // Reset state
        rst_n = 1'b0;
        idle(2);
        chk("rst_ts_rd", 32'(bus.ts_rd), 32'(TS_NONE));
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_any", 32'(bus.rd_rdy_any), 0);
        chk("rst_num", 32'(bus.rd_rdy_num), 0);
        rst_n = 1'b1;
        push_all(TS_NONE);
        sweep("rst_sweep");
        chk("rst_err_after", 32'(bus.err), 0);
        chk("rst_any_after", 32'(bus.rd_rdy_any), 0);

        // Write-to-read latency is exactly two edges
        bus.ts_rd_num = 3'd3;
        io_wr(3, TS_WR_RDY);
        chk("lat_e0", 32'(bus.ts_rd), 32'(TS_NONE));
        step();
        chk("lat_e1", 32'(bus.ts_rd), 32'(TS_NONE));
        step();
        chk("lat_e2", 32'(bus.ts_rd), 32'(TS_WR_RDY));

        // Full life cycle of thread 1
        bus.ts_rd_num = 3'd1;
        io_wr(1, TS_WR_RDY);
        cpu_wr(1, TS_BUSY);
        cpu_wr(1, TS_RD_RDY);
        idle(2);
        chk("t1_state", 32'(bus.ts_rd), 32'(TS_RD_RDY));
        chk("t1_any", 32'(bus.rd_rdy_any), 1);
        chk("t1_num", 32'(bus.rd_rdy_num), 1);
        chk("t1_err", 32'(bus.err), 0);
        io_wr(1, TS_NONE);
        step();
        chk("t1_unload_lag", 32'(bus.rd_rdy_any), 1);
        step();
        chk("t1_unload_any", 32'(bus.rd_rdy_any), 0);
        chk("t1_unload_num", 32'(bus.rd_rdy_num), 0);
        chk("t1_unload_state", 32'(bus.ts_rd), 32'(TS_NONE));

        // Priority scan: threads 5 then 2 become RD_RDY
        io_wr(5, TS_WR_RDY);
        cpu_wr(5, TS_BUSY);
        cpu_wr(5, TS_RD_RDY);
        idle(2);
        chk("scan_5_num", 32'(bus.rd_rdy_num), 5);
        io_wr(2, TS_WR_RDY);
        cpu_wr(2, TS_BUSY);
        cpu_wr(2, TS_RD_RDY);
        idle(2);
        chk("scan_25_num", 32'(bus.rd_rdy_num), 2);
        chk("scan_25_any", 32'(bus.rd_rdy_any), 1);
        io_wr(2, TS_NONE);
        idle(2);
        chk("scan_unload2_num", 32'(bus.rd_rdy_num), 5);
        chk("scan_unload2_any", 32'(bus.rd_rdy_any), 1);
        io_wr(5, TS_NONE);
        idle(2);
        chk("scan_empty_any", 32'(bus.rd_rdy_any), 0);
        chk("scan_err", 32'(bus.err), 0);

        // Illegal CPU transition WR_RDY->RD_RDY on thread 0
        bus.ts_rd_num = 3'd0;
        io_wr(0, TS_WR_RDY);
        cpu_wr(0, TS_RD_RDY);
        chk("ill_err_pre", 32'(bus.err), 0);
        step();
        chk("ill_err", 32'(bus.err), 1);
        step();
        chk("ill_state", 32'(bus.ts_rd), 32'(TS_WR_RDY));
        idle(3);
        chk("ill_err_sticky", 32'(bus.err), 1);
        rst_n = 1'b0;
        step();
        chk("ill_rst_err", 32'(bus.err), 0);
        chk("ill_rst_ts_rd", 32'(bus.ts_rd), 32'(TS_NONE));
        rst_n = 1'b1;

        // Same-thread collision: CPU wins, I/O dropped, error flagged
        io_wr(4, TS_WR_RDY);
        both_wr(4, TS_BUSY, 4, TS_NONE);
        step();
        chk("coll_err", 32'(bus.err), 1);
        read_chk("coll_state", 4, TS_BUSY);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Different threads in one cycle: both applied
        io_wr(2, TS_WR_RDY);
        both_wr(2, TS_BUSY, 3, TS_WR_RDY);
        step();
        read_chk("dual_t2", 2, TS_BUSY);
        read_chk("dual_t3", 3, TS_WR_RDY);
        chk("dual_err", 32'(bus.err), 0);

        // Out-of-range thread number: ignored, error flagged
        io_wr(6, TS_WR_RDY);
        step();
        chk("oor_err", 32'(bus.err), 1);
        exp_q.push_back(32'(TS_NONE));
        exp_q.push_back(32'(TS_NONE));
        exp_q.push_back(32'(TS_BUSY));
        exp_q.push_back(32'(TS_WR_RDY));
        exp_q.push_back(32'(TS_NONE));
        exp_q.push_back(32'(TS_NONE));
        sweep("oor_sweep");

        // Reset while a write sits in stage 1: the write is lost
        io_wr(1, TS_WR_RDY);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        push_all(TS_NONE);
        sweep("rstpipe_sweep");
        chk("rstpipe_err", 32'(bus.err), 0);
        chk("rstpipe_any", 32'(bus.rd_rdy_any), 0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
